vec_alu_seq: RTL and testbench

Sequencer for the lane-sliced vector ALU. It walks a vector instruction element by element and, inside each element, lane-chunk by lane-chunk. For every chunk it drives the ALU's run, index and in_reg_offset inputs and captures the ALU result into a VLEN-bit destination accumulator. It sits between the vector decode stage (start/done handshake) and the ALU instance, which it owns exclusively.

---
 rtl/vec_pkg.sv | 29 ++
 rtl/vec_elem_cnt.sv | 42 ++++
 rtl/vec_alu_seq.sv | 121 ++++++++++++
 tb/tb_vec_alu_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU sequencer.
//   - op_type codes (VV/VX/VI)
//   - ALU opcode constants
//   - sequencer state encoding
//   - sew_bits(): element width in bits from the vsew code
package vec_pkg;

    localparam logic [2:0] OP_VV = 3'b001;
    localparam logic [2:0] OP_VX = 3'b010;
    localparam logic [2:0] OP_VI = 3'b100;

    localparam logic [5:0] ALU_VADD = 6'b000000;
    localparam logic [5:0] ALU_VAND = 6'b001001;
    localparam logic [5:0] ALU_VOR  = 6'b001010;
    localparam logic [5:0] ALU_VXOR = 6'b001011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    // 11 bits holds 8<<7, so out-of-range codes still produce a value that
    // the legality check can reject instead of wrapping.
    function automatic logic [10:0] sew_bits(input logic [2:0] vsew);
        return 11'd8 << vsew;
    endfunction

endpackage

// File: rtl/vec_elem_cnt.sv
// Nested chunk/element counter for the vector ALU sequencer.
//   clk, resetn     : clock, async active-low reset
//   clr             : synchronous clear (held while the sequencer is idle)
//   en              : advance one chunk
//   cpe             : chunks per element
//   vl              : element count
//   chunk, elem     : current position
//   last_chunk/elem : current chunk is the last of its element / element is last
module vec_elem_cnt (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] cpe,
    input  logic [9:0] vl,
    output logic [3:0] chunk,
    output logic [9:0] elem,
    output logic       last_chunk,
    output logic       last_elem
);

    assign last_chunk = (chunk == cpe - 4'd1);
    assign last_elem  = (elem == vl - 10'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chunk <= '0;
            elem  <= '0;
        end else if (clr) begin
            chunk <= '0;
            elem  <= '0;
        end else if (en) begin
            if (last_chunk) begin
                chunk <= '0;
                elem  <= last_elem ? 10'd0 : elem + 10'd1;
            end else begin
                chunk <= chunk + 4'd1;
            end
        end
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Sequencer for the lane-sliced vector ALU. Walks a vector instruction
// element by element and, within each element, LW-bit chunk by chunk,
// driving the ALU and capturing its result into the destination accumulator.
//   clk, resetn          : clock, async active-low reset
//   start                : launch strobe (only honoured in IDLE)
//   opcode/op_type/vsew/vl : command, latched at start
//   busy, done, err      : status; err is only meaningful with done
//   alu_*                : ALU control (run, latched command, chunk index/offset)
//   alu_vd               : ALU result, low LW bits valid
//   vd_out               : VLEN-bit destination accumulator
module vec_alu_seq
    import vec_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [5:0]      opcode,
    input  logic [2:0]      op_type,
    input  logic [2:0]      vsew,
    input  logic [9:0]      vl,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [2:0]      alu_op_type,
    output logic [2:0]      alu_vsew,
    output logic [9:0]      alu_index,
    output logic [3:0]      alu_in_reg_offset,
    input  logic [63:0]     alu_vd,
    output logic [VLEN-1:0] vd_out
);

    localparam int LW = 1 << LANE_WIDTH;
    localparam int IW = $clog2(VLEN);

    seq_state_e state_q;
    logic [9:0] vl_q;
    logic       err_q;

    // Legality of the incoming command, judged in the start cycle.
    logic [10:0] sew_in;
    logic [20:0] bits_in;
    logic        legal;
    assign sew_in  = sew_bits(vsew);
    assign bits_in = 21'(vl) * 21'(sew_in);
    assign legal   = (vsew <= 3'd3) && (sew_in >= 11'(LW)) && (bits_in <= 21'(VLEN));

    // Chunk walk for the latched command.
    logic [10:0] sew_q;
    logic [3:0]  cpe;
    logic [3:0]  chunk;
    logic [9:0]  elem;
    logic        last_chunk, last_elem;
    assign sew_q = sew_bits(alu_vsew);
    assign cpe   = 4'(sew_q >> LANE_WIDTH);

    vec_elem_cnt u_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (state_q == S_IDLE),
        .en         (alu_run),
        .cpe        (cpe),
        .vl         (vl_q),
        .chunk      (chunk),
        .elem       (elem),
        .last_chunk (last_chunk),
        .last_elem  (last_elem)
    );

    // elem*SEW reaches 1023*64, so the index is formed wide and truncated.
    logic [16:0] idx_full;
    logic [IW-1:0] vd_idx;
    assign idx_full = (17'(elem) << ({1'b0, alu_vsew} + 4'd3)) + (17'(chunk) << LANE_WIDTH);
    assign vd_idx   = idx_full[IW-1:0];

    assign alu_run           = (state_q == S_RUN);
    assign alu_index         = alu_run ? idx_full[9:0] : 10'd0;
    assign alu_in_reg_offset = alu_run ? chunk : 4'd0;
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign err               = done & err_q;

    logic unused_bits;
    assign unused_bits = ^{alu_vd[63:LW], idx_full[16:10]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            alu_opcode  <= '0;
            alu_op_type <= '0;
            alu_vsew    <= '0;
            vl_q        <= '0;
            err_q       <= 1'b0;
            vd_out      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    alu_opcode  <= opcode;
                    alu_op_type <= op_type;
                    alu_vsew    <= vsew;
                    vl_q        <= vl;
                    err_q       <= !legal;
                    vd_out      <= '0;
                    state_q     <= (legal && vl != 10'd0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    // ALU is combinational: capture this chunk's result now.
                    vd_out[vd_idx +: LW] <= alu_vd[LW-1:0];
                    if (last_chunk && last_elem) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_seq.sv
module tb_vec_alu_seq;
    import vec_pkg::*;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   opcode = '0;
    logic [2:0]   op_type = OP_VV;
    logic [2:0]   vsew = '0;
    logic [9:0]   vl = '0;
    logic         busy, done, err, alu_run;
    logic [5:0]   alu_opcode;
    logic [2:0]   alu_op_type, alu_vsew;
    logic [9:0]   alu_index;
    logic [3:0]   alu_in_reg_offset;
    logic [63:0]  alu_vd;
    logic [127:0] vd_out;

    always #5 clk = ~clk;

    vec_alu_seq #(.VLEN(128), .LANE_WIDTH(3)) dut (
        .clk(clk), .resetn(resetn), .start(start), .opcode(opcode), .op_type(op_type),
        .vsew(vsew), .vl(vl), .busy(busy), .done(done), .err(err), .alu_run(alu_run),
        .alu_opcode(alu_opcode), .alu_op_type(alu_op_type), .alu_vsew(alu_vsew),
        .alu_index(alu_index), .alu_in_reg_offset(alu_in_reg_offset),
        .alu_vd(alu_vd), .vd_out(vd_out)
    );

    // Stand-in 8-bit-lane ALU: combinational result, carry chained through
    // its own register and cleared on chunk 0.
    logic [127:0] vs1, vs2;
    logic         carry_q = 1'b0;
    logic [7:0]   a8, b8, r8;
    logic         co;
    always_comb begin
        a8 = 8'(vs2 >> alu_index);
        b8 = 8'(vs1 >> alu_index);
        r8 = '0;
        co = 1'b0;
        case (alu_opcode)
            ALU_VADD: {co, r8} = 9'(a8) + 9'(b8) + 9'((alu_in_reg_offset == 4'd0) ? 1'b0 : carry_q);
            ALU_VAND: r8 = a8 & b8;
            ALU_VOR:  r8 = a8 | b8;
            ALU_VXOR: r8 = a8 ^ b8;
            default:  r8 = '0;
        endcase
        alu_vd = {56'd0, r8};
    end
    always @(posedge clk) if (alu_run) carry_q <= co;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model expectations for the command in flight.
    int           exp_n;
    logic         exp_err;
    logic [127:0] exp_vd;
    logic [5:0]   exp_opc;
    int           exp_idx[$];
    int           exp_off[$];

    task automatic model(input logic [5:0] opc, input int sew_code, input int n);
        int sew;
        logic [127:0] mask, ea, eb, er;
        sew = 8 << sew_code;
        exp_idx.delete();
        exp_off.delete();
        exp_opc = opc;
        exp_vd  = '0;
        exp_err = !(sew_code <= 3 && n * sew <= 128);
        exp_n   = 0;
        if (!exp_err) begin
            mask = (128'd1 << sew) - 128'd1;
            for (int e = 0; e < n; e++) begin
                ea = (vs2 >> (e * sew)) & mask;
                eb = (vs1 >> (e * sew)) & mask;
                case (opc)
                    ALU_VADD: er = ea + eb;
                    ALU_VAND: er = ea & eb;
                    ALU_VOR:  er = ea | eb;
                    default:  er = ea ^ eb;
                endcase
                exp_vd |= (er & mask) << (e * sew);
                for (int c = 0; c < sew / 8; c++) begin
                    exp_idx.push_back(e * sew + c * 8);
                    exp_off.push_back(c);
                end
            end
            exp_n = n * (sew / 8);
        end
    endtask

    // Per-cycle compare process, cycle 1 = first cycle after the start edge.
    int go_id = 0, seen_go = 0, cyc = 0;
    bit active = 0, chk_on = 1;
    always @(negedge clk) begin
        if (go_id != seen_go) begin
            seen_go = go_id;
            cyc     = 0;
            active  = 1;
        end
        if (active && chk_on) begin
            cyc++;
            chk("busy", 128'(busy), 128'(cyc <= exp_n + 1));
            chk("alu_run", 128'(alu_run), 128'(cyc <= exp_n));
            chk("done", 128'(done), 128'(cyc == exp_n + 1));
            chk("alu_opcode", 128'(alu_opcode), 128'(exp_opc));
            if (cyc <= exp_n) begin
                chk("alu_index", 128'(alu_index), 128'(exp_idx[cyc-1]));
                chk("offset", 128'(alu_in_reg_offset), 128'(exp_off[cyc-1]));
            end else begin
                chk("idle_index", 128'(alu_index), 128'd0);
                chk("idle_offset", 128'(alu_in_reg_offset), 128'd0);
            end
            if (cyc == exp_n + 1) begin
                chk("err", 128'(err), 128'(exp_err));
                chk("vd_out", vd_out, exp_vd);
                active = 0;
            end
        end
    end

    task automatic run_cmd(input logic [5:0] opc, input int sew_code, input int n, input int re_at);
        int t;
        model(opc, sew_code, n);
        @(posedge clk); #1;
        opcode = opc; op_type = OP_VV; vsew = 3'(sew_code); vl = 10'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        go_id++;
        t = 0;
        do begin
            @(negedge clk); #1;
            t++;
            if (re_at != 0 && cyc == re_at) begin
                start = 1'b1; opcode = ALU_VXOR; vsew = 3'd2; vl = 10'd1;
            end else begin
                start = 1'b0;
            end
        end while (active && t < 300);
        start = 1'b0;
        if (active) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no done after %0d cycles", t);
        end
    endtask

    initial begin
        vs1 = '0; vs2 = '0;
        #12;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done | err | alu_run), 128'd0);
        chk("rst_vd", vd_out, 128'd0);
        chk("rst_idx", 128'({alu_index, alu_in_reg_offset, alu_opcode}), 128'd0);
        @(negedge clk); resetn = 1'b1;

        // bytes, vl=16: 0x02+0x01 everywhere
        vs1 = {16{8'h01}}; vs2 = {16{8'h02}};
        run_cmd(ALU_VADD, 0, 16, 0);
        chk("t1_model_n", 128'(exp_n), 128'd16);
        chk("t1_vd", vd_out, {16{8'h03}});
        @(posedge clk); #1;
        chk("t1_vd_hold", vd_out, {16{8'h03}});

        // words, carry crosses chunk 0->1 but not elements
        vs1 = {4{32'h000000FF}}; vs2 = {4{32'h00000001}};
        run_cmd(ALU_VADD, 2, 4, 0);
        chk("t2_vd", vd_out, {4{32'h00000100}});

        // full-width 64-bit elements with a carry rippling through all chunks
        vs1 = {64'd5, 64'd1}; vs2 = {64'd7, 64'hFFFF_FFFF_FFFF_FFFF};
        run_cmd(ALU_VADD, 3, 2, 0);
        chk("t3_vd", vd_out, {64'd12, 64'd0});

        // halfwords, partial vl: tail stays 0
        vs1 = {8{16'h0F0F}}; vs2 = {8{16'h00FF}};
        run_cmd(ALU_VXOR, 1, 5, 0);
        chk("t4_vd", vd_out, {48'd0, {5{16'h0FF0}}});
        run_cmd(ALU_VOR, 0, 3, 0);

        // vl=0 and illegal commands
        run_cmd(ALU_VAND, 0, 0, 0);
        chk("t5_vd", vd_out, 128'd0);
        run_cmd(ALU_VADD, 3, 4, 0);
        chk("t6_model_err", 128'(exp_err), 128'd1);
        run_cmd(ALU_VADD, 4, 4, 0);

        // start during a run is ignored
        vs1 = {16{8'h10}}; vs2 = {16{8'h21}};
        run_cmd(ALU_VADD, 0, 16, 3);
        chk("t7_vd", vd_out, {16{8'h31}});

        // async reset mid-run
        chk_on = 0;
        vs1 = {16{8'h01}}; vs2 = {16{8'h02}};
        @(posedge clk); #1;
        opcode = ALU_VADD; vsew = 3'd0; vl = 10'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("t8_partial", 128'(vd_out[31:0]), 128'h03030303);
        chk("t8_busy_pre", 128'(busy), 128'd1);
        resetn = 1'b0;
        #1;
        chk("t8_busy", 128'(busy), 128'd0);
        chk("t8_run", 128'(alu_run), 128'd0);
        chk("t8_vd", vd_out, 128'd0);
        @(negedge clk); resetn = 1'b1;
        chk_on = 1;
        vs1 = {16{8'h03}}; vs2 = {16{8'h04}};
        run_cmd(ALU_VADD, 0, 16, 0);
        chk("t9_vd", vd_out, {16{8'h07}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
